// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding, sentinel value
// and the FIFO entry layout (instruction word plus its byte address).
package fetch_pkg;

  localparam logic [31:0] END_INSTR_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on rdata.
// The writer is trusted never to push into a full FIFO or pop an empty one.
module fetch_fifo #(
  parameter int               DEPTH = 4,
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              AW    = $clog2(DEPTH),
  localparam int              CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Storage is cleared on reset so the head reads a known value while empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= INIT;
      end
    end else if (push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_buffer.sv
// Sequential instruction fetcher feeding the CPU through a small FIFO; stops on the
// sentinel word, drains, flushes and raises done. FETCH_STATS_EN adds pop/stall counters.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter int          FLUSH_CYCLES = 5,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter logic [31:0] END_INSTR    = END_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc,
  output logic        done
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] instr_count,
  output logic [31:0] stall_count
`endif
);

  localparam int          CW         = $clog2(DEPTH + 1);
  localparam int          FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES - 1);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic          r_req;
  logic          r_outstanding;
  logic [31:0]   r_fa;
  logic [FW-1:0] r_flush_cnt;
  logic          r_done;

  logic          w_resp;
  logic          w_sentinel;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic          w_busy;
  logic          w_issue;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_after;
  fetch_entry_t  w_wr_entry;
  fetch_entry_t  w_head;

  // Responses only count while a request is in flight; stale ones after reset fall through.
  assign w_resp     = mem_valid && r_outstanding;
  assign w_sentinel = w_resp && (mem_rdata == END_INSTR);
  assign w_push     = w_resp && !w_sentinel;
  assign w_pop      = !w_empty && inst_ready;
  assign w_wr_entry = '{word: mem_rdata, addr: r_fa};

  // Next request may go out as soon as the current one completes, provided the
  // occupancy after this edge leaves room for its response.
  assign w_busy        = r_req || (r_outstanding && !mem_valid);
  assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);
  assign w_issue       = ((r_state == IDLE) && start) ||
                         ((r_state == FETCH) && !w_busy && !w_sentinel &&
                          (w_count_after < CW'(DEPTH)));

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .INIT  ({32'h0, RESET_PC})
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_wr_entry),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_count),
    .empty (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = FETCH;
      FETCH:   if (w_sentinel) w_state_next = DRAIN;
      DRAIN:   if (w_empty) w_state_next = FLUSH;
      FLUSH:   if (r_flush_cnt == FLUSH_LAST) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_req         <= 1'b0;
      r_outstanding <= 1'b0;
      r_fa          <= RESET_PC;
      r_flush_cnt   <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_issue;
      if (r_req)       r_outstanding <= 1'b1;
      else if (w_resp) r_outstanding <= 1'b0;
      if (w_resp) r_fa <= r_fa + 32'd4;
      if ((r_state == FLUSH) && (w_state_next == FLUSH)) r_flush_cnt <= r_flush_cnt + 1'b1;
      else                                               r_flush_cnt <= '0;
      r_done <= (w_state_next == DONE);
    end
  end

  assign mem_req    = r_req;
  assign mem_addr   = r_fa;
  assign inst       = w_head.word;
  assign pc         = w_head.addr;
  assign inst_valid = !w_empty;
  assign done       = r_done;

`ifdef FETCH_STATS_EN
  logic [31:0] r_instr_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_count <= '0;
      r_stall_count <= '0;
    end else if (r_state != DONE) begin
      if (w_pop)                  r_instr_count <= r_instr_count + 32'd1;
      if (!w_empty && !inst_ready) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with a cycle-stepped memory model, plus a
// direct check of fetch_fifo full-occupancy push/pop behaviour.
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset, start, mem_req, mem_valid, inst_valid, inst_ready, done;
  logic [31:0] mem_addr, mem_rdata, inst, pc;
`ifdef FETCH_STATS_EN
  logic [31:0] instr_count, stall_count;
`endif

  logic       f_rst, f_push, f_pop, f_empty;
  logic [7:0] f_wdata, f_rdata;
  logic [2:0] f_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] mem_words [16];
  int          mem_lat;
  bit          pend;
  int          pend_due;
  logic [31:0] pend_addr;
  int          req_cnt;
  logic [31:0] last_req_addr;

  always #5 clk = ~clk;

  instr_fetch_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc         (pc),
    .done       (done)
`ifdef FETCH_STATS_EN
    ,
    .instr_count(instr_count),
    .stall_count(stall_count)
`endif
  );

  fetch_fifo #(.DEPTH(4), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (f_rst),
    .push  (f_push),
    .wdata (f_wdata),
    .pop   (f_pop),
    .rdata (f_rdata),
    .count (f_count),
    .empty (f_empty)
  );

  // Advance to the next falling edge, then play the memory side for this cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
    if (pend && cyc == pend_due) begin
      mem_valid = 1'b1;
      mem_rdata = mem_words[pend_addr[5:2]];
      pend      = 1'b0;
    end
    if (mem_req === 1'b1) begin
      req_cnt++;
      last_req_addr = mem_addr;
      pend          = 1'b1;
      pend_due      = cyc + mem_lat;
      pend_addr     = mem_addr;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0; pend = 1'b0;
    for (int i = 0; i < 16; i++) mem_words[i] = 32'h0;
    tick();
    tick();
    reset   = 1'b0;
    req_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0;
    tick();
    checks += 6;
    if (mem_req !== 1'b0)     begin failures++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    if (mem_addr !== 32'h0)   begin failures++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    if (inst !== 32'h0)       begin failures++; $display("FAIL reset_inst got %h exp 0", inst); end
    if (inst_valid !== 1'b0)  begin failures++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    if (pc !== 32'h0)         begin failures++; $display("FAIL reset_pc got %h exp 0", pc); end
    if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got %b exp 0", done); end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL idle_no_start req=%b valid=%b exp 0/0", mem_req, inst_valid);
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_program();
    logic [31:0] exp_w [3];
    int c0, n_seen, done_cyc;
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
    do_reset();
    mem_words[0] = 32'h11; mem_words[1] = 32'h22; mem_words[2] = 32'h33; mem_words[3] = 32'hFFFF_FFFF;
    mem_lat = 1; inst_ready = 1'b1;
    tick(); c0 = cyc; start = 1'b1;
    n_seen = 0; done_cyc = -1;
    for (int i = 0; i < 30; i++) begin
      tick(); start = 1'b0;
      if (inst_valid === 1'b1) begin
        checks++;
        if (n_seen >= 3) begin
          failures++; $display("FAIL prog_extra_inst got %h at cycle %0d exp none", inst, cyc - c0);
        end else if (inst !== exp_w[n_seen] || pc !== 32'(4 * n_seen) || (cyc - c0) != 3 + 2 * n_seen) begin
          failures++;
          $display("FAIL prog_inst%0d got %h pc %h cyc %0d exp %h pc %h cyc %0d", n_seen, inst, pc,
                   cyc - c0, exp_w[n_seen], 32'(4 * n_seen), 3 + 2 * n_seen);
        end
        n_seen++;
      end
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc - c0;
    end
    checks += 4;
    if (n_seen != 3)              begin failures++; $display("FAIL prog_inst_count got %0d exp 3", n_seen); end
    if (done_cyc != 15)           begin failures++; $display("FAIL prog_done_cycle got %0d exp 15", done_cyc); end
    if (req_cnt != 4)             begin failures++; $display("FAIL prog_req_count got %0d exp 4", req_cnt); end
    if (last_req_addr !== 32'd12) begin failures++; $display("FAIL prog_last_addr got %h exp c", last_req_addr); end
    $display("test_program done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_backpressure();
    int c0, held;
    do_reset();
    for (int i = 0; i < 8; i++) mem_words[i] = 32'h11 * (i + 1);
    mem_lat = 1; inst_ready = 1'b0;
    tick(); c0 = cyc; start = 1'b1;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); start = 1'b0;
      if (cyc - c0 >= 3 && inst_valid === 1'b1 && inst === 32'h11 && pc === 32'h0) held++;
    end
    checks += 2;
    if (held != 18)  begin failures++; $display("FAIL bp_head_held got %0d cycles exp 18", held); end
    if (req_cnt != 4) begin failures++; $display("FAIL bp_req_count got %0d exp 4", req_cnt); end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checks += 3;
    if (mem_req !== 1'b1 || mem_addr !== 32'd16) begin
      failures++; $display("FAIL bp_fifth_req got req=%b addr=%h exp 1/10", mem_req, mem_addr);
    end
    if (req_cnt != 5) begin failures++; $display("FAIL bp_req_after_pop got %0d exp 5", req_cnt); end
    if (inst !== 32'h22 || pc !== 32'h4) begin
      failures++; $display("FAIL bp_next_head got %h pc %h exp 22 pc 4", inst, pc);
    end
    $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_fifo_full();
    f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_wdata = 8'h0;
    tick();
    f_rst = 1'b0;
    checks++;
    if (f_count !== 3'd0 || f_empty !== 1'b1) begin
      failures++; $display("FAIL fifo_reset got count %0d empty %b exp 0/1", f_count, f_empty);
    end
    for (int k = 0; k < 4; k++) begin
      f_push = 1'b1; f_wdata = 8'hA0 + 8'(k);
      tick();
    end
    f_push = 1'b0;
    checks++;
    if (f_count !== 3'd4 || f_rdata !== 8'hA0) begin
      failures++; $display("FAIL fifo_full got count %0d head %h exp 4/a0", f_count, f_rdata);
    end
    f_push = 1'b1; f_pop = 1'b1; f_wdata = 8'hA4;
    tick();
    f_push = 1'b0; f_pop = 1'b0;
    checks++;
    if (f_count !== 3'd4 || f_rdata !== 8'hA1) begin
      failures++; $display("FAIL fifo_push_pop_full got count %0d head %h exp 4/a1", f_count, f_rdata);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (f_rdata !== 8'hA1 + 8'(k)) begin
        failures++; $display("FAIL fifo_order%0d got %h exp %h", k, f_rdata, 8'hA1 + 8'(k));
      end
      f_pop = 1'b1;
      tick();
      f_pop = 1'b0;
    end
    checks++;
    if (f_count !== 3'd0 || f_empty !== 1'b1) begin
      failures++; $display("FAIL fifo_drained got count %0d empty %b exp 0/1", f_count, f_empty);
    end
    $display("test_fifo_full done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_outstanding();
    int quiet;
    do_reset();
    mem_words[0] = 32'h11; mem_words[1] = 32'h22;
    mem_lat = 3; inst_ready = 1'b0;
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin failures++; $display("FAIL rst_first_req got %b exp 1", mem_req); end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 32'h0 || mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rst_async got req=%b valid=%b pc=%h addr=%h exp 0/0/0/0", mem_req, inst_valid, pc, mem_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (mem_valid !== 1'b1) begin failures++; $display("FAIL rst_late_resp_driven got %b exp 1", mem_valid); end
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (inst_valid === 1'b0 && mem_req === 1'b0 && pc === 32'h0 && done === 1'b0) quiet++;
    end
    checks++;
    if (quiet != 4) begin failures++; $display("FAIL rst_stale_ignored got %0d quiet cycles exp 4", quiet); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL rst_restart got req=%b addr=%h exp 1/0", mem_req, mem_addr);
    end
    $display("test_reset_outstanding done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_sentinel_first();
    int c0, saw_valid, done_cyc;
    do_reset();
    mem_words[0] = 32'hFFFF_FFFF;
    mem_lat = 3; inst_ready = 1'b1;
    tick(); c0 = cyc; start = 1'b1;
    saw_valid = 0; done_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick(); start = 1'b0;
      if (inst_valid === 1'b1) saw_valid++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc - c0;
    end
    checks += 4;
    if (saw_valid != 0) begin failures++; $display("FAIL sent_no_push got %0d valid cycles exp 0", saw_valid); end
    if (done_cyc != 11) begin failures++; $display("FAIL sent_done_cycle got %0d exp 11", done_cyc); end
    if (req_cnt != 1)   begin failures++; $display("FAIL sent_req_count got %0d exp 1", req_cnt); end
    if (done !== 1'b1)  begin failures++; $display("FAIL sent_done_sticky got %b exp 1", done); end
    $display("test_sentinel_first done checks=%0d failures=%0d", checks, failures);
  endtask

`ifdef FETCH_STATS_EN
  task automatic test_stats();
    int stalls;
    do_reset();
    mem_words[0] = 32'h11; mem_words[1] = 32'h22; mem_words[2] = 32'h33; mem_words[3] = 32'hFFFF_FFFF;
    mem_lat = 1; inst_ready = 1'b0;
    tick(); start = 1'b1;
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); start = 1'b0;
      inst_ready = (inst_valid === 1'b1 && stalls < 7) ? 1'b0 : 1'b1;
      if (inst_valid === 1'b1 && inst_ready === 1'b0) stalls++;
    end
    checks += 3;
    if (done !== 1'b1)            begin failures++; $display("FAIL stats_done got %b exp 1", done); end
    if (instr_count !== 32'd3)    begin failures++; $display("FAIL stats_instr got %0d exp 3", instr_count); end
    if (stall_count !== 32'd7)    begin failures++; $display("FAIL stats_stall got %0d exp 7", stall_count); end
    $display("test_stats done checks=%0d failures=%0d", checks, failures);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; inst_ready = 1'b0; mem_valid = 1'b0; mem_rdata = 32'h0;
    f_rst = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_wdata = 8'h0;
    mem_lat = 1; pend = 1'b0; pend_due = 0; pend_addr = 32'h0; req_cnt = 0; last_req_addr = 32'h0;
    for (int i = 0; i < 16; i++) mem_words[i] = 32'h0;
    test_reset();
    test_program();
    test_backpressure();
    test_fifo_full();
    test_reset_outstanding();
    test_sentinel_first();
`ifdef FETCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
